queue_4x4b_rtl: RTL and testbench



---
 rtl/queue_4x4b_rtl.sv | 114 +++++++++++
 tb/tb_queue_4x4b_rtl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/queue_4x4b_rtl.sv
// Four-entry x 4-bit FIFO: control FSM plus its 1r1w register file.
// Latency: enqueue at edge N is visible at ostream after edge N (no bypass); 1 msg/cycle sustained.
// Backpressure: istream_rdy low only when full or in reset; no pipelined accept when full.

// Storage: 4 x 4-bit register file, synchronous write, combinational read, not reset.
module queue_4x4b_rf (
    input  logic       clk,
    input  logic       wen,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] raddr,
    output logic [3:0] rdata
);
    logic [3:0] mem [4];

    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// Queue control: pointers, occupancy counter and EMPTY/PARTIAL/FULL state.
module queue_4x4b_rtl (
    input  logic       clk,
    input  logic       rst,
    input  logic       istream_val,
    output logic       istream_rdy,
    input  logic [3:0] istream_msg,
    output logic       ostream_val,
    input  logic       ostream_rdy,
    output logic [3:0] ostream_msg,
    output logic [2:0] count
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] enq_ptr;
    logic [1:0] deq_ptr;
    logic [2:0] occ;
    logic       enq_fire;
    logic       deq_fire;
    logic [3:0] rdata;

    // Outputs decode from state only; rst also gates the producer handshake.
    assign istream_rdy = (state != FULL) && !rst;
    assign ostream_val = (state == PARTIAL) || (state == FULL);
    assign ostream_msg = ostream_val ? rdata : 4'b0000;
    assign count       = occ;

    assign enq_fire = istream_val && istream_rdy;
    assign deq_fire = ostream_val && ostream_rdy;

    queue_4x4b_rf u_rf (
        .clk   (clk),
        .wen   (enq_fire),
        .waddr (enq_ptr),
        .wdata (istream_msg),
        .raddr (deq_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (enq_fire)
                    state_nxt = PARTIAL;
            end
            PARTIAL: begin
                if (enq_fire && !deq_fire && (occ == 3'd3))
                    state_nxt = FULL;
                else if (deq_fire && !enq_fire && (occ == 3'd1))
                    state_nxt = EMPTY;
            end
            FULL: begin
                if (deq_fire)
                    state_nxt = PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Pointers wrap by natural 2-bit overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enq_ptr <= 2'd0;
            deq_ptr <= 2'd0;
            occ     <= 3'd0;
        end else begin
            if (enq_fire)
                enq_ptr <= enq_ptr + 2'd1;
            if (deq_fire)
                deq_ptr <= deq_ptr + 2'd1;
            case ({enq_fire, deq_fire})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_queue_4x4b_rtl.sv
// Directed bench for queue_4x4b_rtl: stimulus pushes expected messages, a monitor pops them on dequeue.
module tb_queue_4x4b_rtl;
    logic       clk;
    logic       rst;
    logic       istream_val;
    logic       istream_rdy;
    logic [3:0] istream_msg;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [3:0] ostream_msg;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    queue_4x4b_rtl dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are settled when this returns.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Monitor: a dequeue fires at the next edge whenever val and rdy are both high mid-cycle.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (ostream_val && ostream_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq_unexpected: got msg %0h with no expected entry", ostream_msg);
                end else begin
                    e = exp_q.pop_front();
                    chk("deq_msg", int'(ostream_msg), int'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        istream_val = 1'b0;
        istream_msg = 4'h0;
        ostream_rdy = 1'b0;

        // Reset held for two cycles
        #3;
        chk("rst_irdy", int'(istream_rdy), 0);
        chk("rst_oval", int'(ostream_val), 0);
        chk("rst_omsg", int'(ostream_msg), 0);
        chk("rst_count", int'(count), 0);
        cyc();
        cyc();
        chk("rst_irdy_held", int'(istream_rdy), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_irdy", int'(istream_rdy), 1);
        chk("post_rst_oval", int'(ostream_val), 0);
        chk("post_rst_omsg", int'(ostream_msg), 0);
        chk("post_rst_count", int'(count), 0);

        // Single message, no bypass
        istream_val = 1'b1;
        istream_msg = 4'hA;
        exp_q.push_back(4'hA);
        cyc();
        istream_val = 1'b0;
        chk("single_oval", int'(ostream_val), 1);
        chk("single_omsg", int'(ostream_msg), 4'hA);
        chk("single_count", int'(count), 1);
        ostream_rdy = 1'b1;
        cyc();
        ostream_rdy = 1'b0;
        chk("single_drain_count", int'(count), 0);
        chk("single_drain_oval", int'(ostream_val), 0);
        chk("single_drain_omsg", int'(ostream_msg), 0);

        // Fill to four, reject a fifth, drain in order
        istream_val = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            istream_msg = 4'(i);
            exp_q.push_back(4'(i));
            cyc();
        end
        chk("full_irdy", int'(istream_rdy), 0);
        chk("full_count", int'(count), 4);
        istream_msg = 4'h5;
        cyc();
        istream_val = 1'b0;
        chk("full_reject_count", int'(count), 4);
        chk("full_reject_head", int'(ostream_msg), 1);
        ostream_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        ostream_rdy = 1'b0;
        chk("drain_count", int'(count), 0);
        chk("drain_oval", int'(ostream_val), 0);

        // Streaming 0..9: count holds at 1, pointers wrap
        ostream_rdy = 1'b1;
        istream_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            istream_msg = 4'(i);
            exp_q.push_back(4'(i));
            cyc();
            chk("stream_count", int'(count), 1);
        end
        istream_val = 1'b0;
        cyc();
        ostream_rdy = 1'b0;
        chk("stream_end_count", int'(count), 0);

        // Full with consumer ready: head leaves, 4'hF refused
        istream_val = 1'b1;
        istream_msg = 4'h7; exp_q.push_back(4'h7); cyc();
        istream_msg = 4'h8; exp_q.push_back(4'h8); cyc();
        istream_msg = 4'h9; exp_q.push_back(4'h9); cyc();
        istream_msg = 4'hC; exp_q.push_back(4'hC); cyc();
        chk("full2_count", int'(count), 4);
        istream_msg = 4'hF;
        ostream_rdy = 1'b1;
        cyc();
        chk("full2_irdy_after", int'(istream_rdy), 1);
        chk("full2_count_after", int'(count), 3);
        istream_val = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        ostream_rdy = 1'b0;
        chk("full2_drain_count", int'(count), 0);

        // Async reset mid-stream discards queued entries
        istream_val = 1'b1;
        istream_msg = 4'h3; cyc();
        istream_msg = 4'h5; cyc();
        istream_val = 1'b0;
        chk("pre_arst_count", int'(count), 2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_oval", int'(ostream_val), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_irdy", int'(istream_rdy), 0);
        chk("arst_omsg", int'(ostream_msg), 0);
        cyc();
        rst = 1'b0;
        istream_val = 1'b1;
        istream_msg = 4'h6;
        exp_q.push_back(4'h6);
        cyc();
        istream_val = 1'b0;
        chk("after_arst_oval", int'(ostream_val), 1);
        chk("after_arst_omsg", int'(ostream_msg), 4'h6);
        ostream_rdy = 1'b1;
        cyc();
        ostream_rdy = 1'b0;
        chk("after_arst_count", int'(count), 0);

        cyc();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
